// File: rtl/spmv_fp_row_accum.sv
// Floating-point row accumulator for SpMV: folds a handshaked stream of products into a running
// sum (align / add / normalise+round), emitting one rounded sum with sticky flags per row.
module spmv_fp_row_accum #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [EXP_W+MAN_W:0] i_data,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [EXP_W+MAN_W:0] o_sum,
  output logic                 o_ovf,
  output logic                 o_nan,
  output logic [CNT_W-1:0]     o_count
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 4;
  localparam int SUM_W = SIG_W + 1;
  localparam int E_W   = EXP_W + 2;
  localparam int LZ_W  = $clog2(SIG_W + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

  function automatic logic [LZ_W-1:0] clz(input logic [SIG_W-1:0] v);
    logic [LZ_W-1:0] n;
    logic            hit;
    n   = {LZ_W{1'b0}};
    hit = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      hit = hit | v[i];
      n   = n + {{(LZ_W-1){1'b0}}, ~hit};
    end
    return n;
  endfunction

  state_t               state_r, state_s;
  logic [W-1:0]         acc_r, in_r, spec_val_r;
  logic                 last_r, ovf_r, nan_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [SIG_W-1:0]     big_r, sml_r;
  logic [EXP_W-1:0]     exp_r;
  logic                 sign_r, sub_r, spec_r, spec_nan_r;
  logic [SUM_W-1:0]     sum_r;
  logic                 o_ready_r, o_valid_r, o_ovf_r, o_nan_r;
  logic [W-1:0]         o_sum_r;
  logic [CNT_W-1:0]     o_count_r;

  logic [EXP_W-1:0]     a_exp_s, b_exp_s, bexp_s, sexp_s, diff_s;
  logic [SIG_W-1:0]     a_sig_s, b_sig_s, big_s, sml_s, aligned_s;
  logic                 a_nan_s, b_nan_s, a_inf_s, b_inf_s, swap_s, bsign_s, sticky_s;
  logic                 spec_s, spec_nan_s;
  logic [W-1:0]         spec_val_s;
  logic [SUM_W-1:0]     sum_s;
  logic [LZ_W-1:0]      lz_s;
  logic [SIG_W-1:0]     m_s;
  logic [E_W-1:0]       e_s, e_rnd_s;
  logic                 inc_s;
  logic [MAN_W+1:0]     rnd_s;
  logic [MAN_W-1:0]     man_s;
  logic [W-1:0]         res_s;
  logic                 res_ovf_s, res_nan_s;

  // Operand classification, magnitude ordering and right-alignment of the smaller significand
  always_comb begin
    a_exp_s = acc_r[W-2:MAN_W];
    b_exp_s = in_r[W-2:MAN_W];
    a_sig_s = (a_exp_s == {EXP_W{1'b0}}) ? {SIG_W{1'b0}} : {1'b1, acc_r[MAN_W-1:0], 3'b000};
    b_sig_s = (b_exp_s == {EXP_W{1'b0}}) ? {SIG_W{1'b0}} : {1'b1, in_r[MAN_W-1:0], 3'b000};
    a_nan_s = (a_exp_s == EXP_ONES) && (acc_r[MAN_W-1:0] != {MAN_W{1'b0}});
    b_nan_s = (b_exp_s == EXP_ONES) && (in_r[MAN_W-1:0] != {MAN_W{1'b0}});
    a_inf_s = (a_exp_s == EXP_ONES) && (acc_r[MAN_W-1:0] == {MAN_W{1'b0}});
    b_inf_s = (b_exp_s == EXP_ONES) && (in_r[MAN_W-1:0] == {MAN_W{1'b0}});
    swap_s  = in_r[W-2:0] > acc_r[W-2:0];
    if (swap_s) begin
      big_s = b_sig_s; sml_s = a_sig_s; bexp_s = b_exp_s; sexp_s = a_exp_s; bsign_s = in_r[W-1];
    end else begin
      big_s = a_sig_s; sml_s = b_sig_s; bexp_s = a_exp_s; sexp_s = b_exp_s; bsign_s = acc_r[W-1];
    end
    diff_s   = bexp_s - sexp_s;
    sticky_s = 1'b0;
    for (int i = 0; i < SIG_W; i++) begin
      sticky_s = sticky_s | (sml_s[i] & (i < int'(diff_s)));
    end
    if (int'(diff_s) >= MAN_W + 3) begin
      aligned_s = {{(SIG_W-1){1'b0}}, |sml_s};
    end else begin
      aligned_s = (sml_s >> diff_s) | {{(SIG_W-1){1'b0}}, sticky_s};
    end
    spec_s     = 1'b1;
    spec_nan_s = 1'b0;
    spec_val_s = QNAN;
    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (acc_r[W-1] != in_r[W-1]))) begin
      spec_nan_s = 1'b1;
    end else if (a_inf_s) begin
      spec_val_s = acc_r;
    end else if (b_inf_s) begin
      spec_val_s = in_r;
    end else begin
      spec_s = 1'b0;
    end
  end

  // Magnitude add or subtract (larger minus smaller, so never negative)
  always_comb begin
    if (sub_r) begin
      sum_s = {1'b0, big_r} - {1'b0, sml_r};
    end else begin
      sum_s = {1'b0, big_r} + {1'b0, sml_r};
    end
  end

  // Renormalise, round to nearest even, then resolve specials / overflow / flush-to-zero
  always_comb begin
    lz_s = clz(sum_r[SIG_W-1:0]);
    if (sum_r[SUM_W-1]) begin
      m_s = {sum_r[SUM_W-1:2], sum_r[1] | sum_r[0]};
      e_s = E_W'(exp_r) + E_W'(1);
    end else begin
      m_s = sum_r[SIG_W-1:0] << lz_s;
      e_s = E_W'(exp_r) - E_W'(lz_s);
    end
    inc_s = m_s[2] & (m_s[1] | m_s[0] | m_s[3]);
    rnd_s = {1'b0, m_s[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, inc_s};
    if (rnd_s[MAN_W+1]) begin
      e_rnd_s = e_s + E_W'(1);
      man_s   = rnd_s[MAN_W:1];
    end else begin
      e_rnd_s = e_s;
      man_s   = rnd_s[MAN_W-1:0];
    end
    res_s     = {W{1'b0}};
    res_ovf_s = 1'b0;
    res_nan_s = 1'b0;
    if (spec_r) begin
      res_s     = spec_val_r;
      res_nan_s = spec_nan_r;
    end else if (sum_r == {SUM_W{1'b0}}) begin
      res_s = {W{1'b0}};
    end else if (e_rnd_s[E_W-1] || (e_rnd_s == {E_W{1'b0}})) begin
      res_s = {W{1'b0}};
    end else if (e_rnd_s >= {2'b00, EXP_ONES}) begin
      res_s     = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
      res_ovf_s = 1'b1;
    end else begin
      res_s = {sign_r, e_rnd_s[EXP_W-1:0], man_s};
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  if (i_valid) state_s = S_ALIGN; else state_s = S_IDLE;
      S_ALIGN: state_s = S_ADD;
      S_ADD:   state_s = S_NORM;
      S_NORM:  if (last_r) state_s = S_OUT; else state_s = S_IDLE;
      S_OUT:   if (i_ready) state_s = S_IDLE; else state_s = S_OUT;
      default: state_s = S_IDLE;
    endcase
  end

  // State register; ready is registered from the next state so it is high exactly in S_IDLE
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r   <= S_IDLE;
      o_ready_r <= 1'b1;
    end else begin
      state_r   <= state_s;
      o_ready_r <= (state_s == S_IDLE);
    end
  end

  // Datapath pipeline registers, accumulator, row flags and output holding registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      acc_r <= {W{1'b0}}; in_r <= {W{1'b0}}; last_r <= 1'b0; cnt_r <= {CNT_W{1'b0}};
      ovf_r <= 1'b0; nan_r <= 1'b0; big_r <= {SIG_W{1'b0}}; sml_r <= {SIG_W{1'b0}};
      exp_r <= {EXP_W{1'b0}}; sign_r <= 1'b0; sub_r <= 1'b0; spec_r <= 1'b0;
      spec_nan_r <= 1'b0; spec_val_r <= {W{1'b0}}; sum_r <= {SUM_W{1'b0}};
      o_valid_r <= 1'b0; o_sum_r <= {W{1'b0}}; o_ovf_r <= 1'b0; o_nan_r <= 1'b0;
      o_count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (i_valid) begin
            in_r   <= i_data;
            last_r <= i_last;
            cnt_r  <= cnt_r + CNT_W'(1);
          end
        end
        S_ALIGN: begin
          big_r      <= big_s;
          sml_r      <= aligned_s;
          exp_r      <= bexp_s;
          sign_r     <= bsign_s;
          sub_r      <= acc_r[W-1] ^ in_r[W-1];
          spec_r     <= spec_s;
          spec_nan_r <= spec_nan_s;
          spec_val_r <= spec_val_s;
        end
        S_ADD: sum_r <= sum_s;
        S_NORM: begin
          acc_r <= res_s;
          ovf_r <= ovf_r | res_ovf_s;
          nan_r <= nan_r | res_nan_s;
          if (last_r) begin
            o_valid_r <= 1'b1;
            o_sum_r   <= res_s;
            o_ovf_r   <= ovf_r | res_ovf_s;
            o_nan_r   <= nan_r | res_nan_s;
            o_count_r <= cnt_r;
          end
        end
        S_OUT: begin
          if (i_ready) begin
            o_valid_r <= 1'b0;
            acc_r     <= {W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ovf_r     <= 1'b0;
            nan_r     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready = o_ready_r;
  assign o_valid = o_valid_r;
  assign o_sum   = o_sum_r;
  assign o_ovf   = o_ovf_r;
  assign o_nan   = o_nan_r;
  assign o_count = o_count_r;
endmodule
